// File: rtl/mult8_seq_4x4_ctrl.sv
// Sequential 8x8 unsigned multiplier that drives one external 4x4 core through four
// nibble sub-products and shift-accumulates them into a 16-bit product.
module mult8_seq_4x4_ctrl #(
    parameter int unsigned MUL_LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    input  logic [7:0]  mul_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    // Any non-zero latency selects the registered-core timing (one wait edge per step).
    localparam bit HasWait = (MUL_LAT != 0);

    state_e      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic        phase_q, phase_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] p_q, p_d;
    logic        out_valid_q, out_valid_d;

    logic [15:0] addend;
    logic [15:0] acc_sum;

    always_comb begin
        mul_a = 4'h0;
        mul_b = 4'h0;
        if (state_q == StCalc) begin
            unique case (step_q)
                2'd0: begin
                    mul_a = a_q[3:0];
                    mul_b = b_q[3:0];
                end
                2'd1: begin
                    mul_a = a_q[3:0];
                    mul_b = b_q[7:4];
                end
                2'd2: begin
                    mul_a = a_q[7:4];
                    mul_b = b_q[3:0];
                end
                2'd3: begin
                    mul_a = a_q[7:4];
                    mul_b = b_q[7:4];
                end
                default: begin
                    mul_a = 4'h0;
                    mul_b = 4'h0;
                end
            endcase
        end
    end

    // Core result is taken unmodified; the sum wraps so an approximate core cannot overflow it.
    always_comb begin
        addend = 16'h0000;
        unique case (step_q)
            2'd0:    addend = {8'h00, mul_p};
            2'd1:    addend = {4'h0, mul_p, 4'h0};
            2'd2:    addend = {4'h0, mul_p, 4'h0};
            2'd3:    addend = {mul_p, 8'h00};
            default: addend = 16'h0000;
        endcase
        acc_sum = acc_q + addend;
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        phase_d     = phase_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        p_d         = p_q;
        out_valid_d = out_valid_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = 16'h0000;
                    step_d  = 2'd0;
                    phase_d = 1'b0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (HasWait && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    acc_d   = acc_sum;
                    if (step_q == 2'd3) begin
                        p_d         = acc_sum;
                        out_valid_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    step_d      = 2'd0;
                    state_d     = StIdle;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            step_q      <= 2'd0;
            phase_q     <= 1'b0;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            acc_q       <= 16'h0000;
            p_q         <= 16'h0000;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            phase_q     <= phase_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign p         = p_q;

endmodule

// File: tb/tb_mult8_seq_4x4_ctrl.sv
// Directed bench: a combinational core on a MUL_LAT=0 instance and a registered ideal core
// on a MUL_LAT=1 instance, checked against hand-computed products.
module tb_mult8_seq_4x4_ctrl;

    logic clk;
    logic rst_n;

    logic        in_valid0, in_ready0, out_valid0, out_ready0, busy0;
    logic [7:0]  a0, b0, mul_p0;
    logic [3:0]  mul_a0, mul_b0;
    logic [15:0] p0;
    logic [1:0]  core_mode;

    logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [7:0]  a1, b1, mul_p1;
    logic [3:0]  mul_a1, mul_b1;
    logic [15:0] p1;

    int n_checks;
    int n_errors;

    mult8_seq_4x4_ctrl #(.MUL_LAT(0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .a         (a0),
        .b         (b0),
        .mul_a     (mul_a0),
        .mul_b     (mul_b0),
        .mul_p     (mul_p0),
        .out_valid (out_valid0),
        .out_ready (out_ready0),
        .p         (p0),
        .busy      (busy0)
    );

    mult8_seq_4x4_ctrl #(.MUL_LAT(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .mul_a     (mul_a1),
        .mul_b     (mul_b1),
        .mul_p     (mul_p1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .p         (p1),
        .busy      (busy1)
    );

    // Core models: 0 ideal, 1 ideal+1, 2 stuck at 0xFF.
    always_comb begin
        mul_p0 = {4'h0, mul_a0} * {4'h0, mul_b0};
        case (core_mode)
            2'd1:    mul_p0 = ({4'h0, mul_a0} * {4'h0, mul_b0}) + 8'd1;
            2'd2:    mul_p0 = 8'hFF;
            default: mul_p0 = {4'h0, mul_a0} * {4'h0, mul_b0};
        endcase
    end

    always_ff @(posedge clk) mul_p1 <= {4'h0, mul_a1} * {4'h0, mul_b1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run0(input logic [7:0] ia, input logic [7:0] ib, input logic [15:0] ep,
                        input string tag);
        logic [3:0] ea [4];
        logic [3:0] eb [4];
        ea[0] = ia[3:0]; eb[0] = ib[3:0];
        ea[1] = ia[3:0]; eb[1] = ib[7:4];
        ea[2] = ia[7:4]; eb[2] = ib[3:0];
        ea[3] = ia[7:4]; eb[3] = ib[7:4];
        @(negedge clk);
        check_eq({tag, " in_ready idle"}, 32'(in_ready0), 32'd1);
        in_valid0 = 1'b1;
        a0 = ia;
        b0 = ib;
        @(posedge clk);
        #1 in_valid0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq($sformatf("%s mul_a step%0d", tag, k), 32'(mul_a0), 32'(ea[k]));
            check_eq($sformatf("%s mul_b step%0d", tag, k), 32'(mul_b0), 32'(eb[k]));
            check_eq($sformatf("%s out_valid low step%0d", tag, k), 32'(out_valid0), 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        check_eq({tag, " out_valid"}, 32'(out_valid0), 32'd1);
        check_eq({tag, " p"}, 32'(p0), 32'(ep));
        check_eq({tag, " busy"}, 32'(busy0), 32'd1);
        out_ready0 = 1'b1;
        @(posedge clk);
        #1 out_ready0 = 1'b0;
        @(negedge clk);
        check_eq({tag, " out_valid drained"}, 32'(out_valid0), 32'd0);
        check_eq({tag, " p retained"}, 32'(p0), 32'(ep));
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        core_mode  = 2'd0;
        in_valid0  = 1'b0;
        out_ready0 = 1'b0;
        a0         = 8'h00;
        b0         = 8'h00;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        a1         = 8'h00;
        b1         = 8'h00;

        #2;
        check_eq("rst out_valid", 32'(out_valid0), 32'd0);
        check_eq("rst p", 32'(p0), 32'd0);
        check_eq("rst busy", 32'(busy0), 32'd0);
        check_eq("rst in_ready", 32'(in_ready0), 32'd1);
        check_eq("rst mul_a", 32'(mul_a0), 32'd0);
        check_eq("rst mul_b", 32'(mul_b0), 32'd0);
        check_eq("rst1 in_ready", 32'(in_ready1), 32'd1);
        check_eq("rst1 p", 32'(p1), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run0(8'h12, 8'h34, 16'h03A8, "ideal 12x34");
        run0(8'hFF, 8'hFF, 16'hFE01, "ideal FFxFF");
        run0(8'h00, 8'hA5, 16'h0000, "ideal 00xA5");
        core_mode = 2'd1;
        run0(8'h12, 8'h34, 16'h04C9, "err+1 12x34");
        core_mode = 2'd2;
        run0(8'h12, 8'h34, 16'h1FDF, "stuck FF wrap");
        core_mode = 2'd0;

        // Registered core: each nibble pair held two cycles, result after 8 edges.
        @(negedge clk);
        in_valid1 = 1'b1;
        a1 = 8'h12;
        b1 = 8'h34;
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [3:0] xa;
            logic [3:0] xb;
            xa = (k < 4) ? 4'h2 : 4'h1;
            xb = ((k / 2) % 2 == 0) ? 4'h4 : 4'h3;
            @(negedge clk);
            check_eq($sformatf("lat1 mul_a cyc%0d", k), 32'(mul_a1), 32'(xa));
            check_eq($sformatf("lat1 mul_b cyc%0d", k), 32'(mul_b1), 32'(xb));
            check_eq($sformatf("lat1 out_valid low cyc%0d", k), 32'(out_valid1), 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        check_eq("lat1 out_valid", 32'(out_valid1), 32'd1);
        check_eq("lat1 p", 32'(p1), 32'h03A8);
        out_ready1 = 1'b1;
        @(posedge clk);
        #1 out_ready1 = 1'b0;
        @(negedge clk);
        check_eq("lat1 drained", 32'(out_valid1), 32'd0);

        // Backpressure with in_valid pulses while DONE.
        @(negedge clk);
        in_valid0 = 1'b1;
        a0 = 8'h12;
        b0 = 8'h34;
        @(posedge clk);
        #1 in_valid0 = 1'b0;
        repeat (4) @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq($sformatf("bp out_valid cyc%0d", k), 32'(out_valid0), 32'd1);
            check_eq($sformatf("bp p cyc%0d", k), 32'(p0), 32'h03A8);
            check_eq($sformatf("bp in_ready cyc%0d", k), 32'(in_ready0), 32'd0);
            in_valid0 = (k != 1);
            a0 = 8'h77;
            b0 = 8'h66;
            @(posedge clk);
        end
        @(negedge clk);
        check_eq("bp p held", 32'(p0), 32'h03A8);
        in_valid0 = 1'b1;
        a0 = 8'h03;
        b0 = 8'h05;
        out_ready0 = 1'b1;
        @(posedge clk);
        #1 out_ready0 = 1'b0;
        @(negedge clk);
        check_eq("bp drained out_valid", 32'(out_valid0), 32'd0);
        check_eq("bp in_ready after drain", 32'(in_ready0), 32'd1);
        @(posedge clk);
        #1 in_valid0 = 1'b0;
        @(negedge clk);
        check_eq("bp next accepted", 32'(busy0), 32'd1);
        check_eq("bp next mul_a", 32'(mul_a0), 32'd3);
        check_eq("bp next mul_b", 32'(mul_b0), 32'd5);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("bp next p", 32'(p0), 32'h000F);
        out_ready0 = 1'b1;
        @(posedge clk);
        #1 out_ready0 = 1'b0;

        run0(8'h12, 8'h34, 16'h03A8, "pre-reset");

        // Asynchronous reset in step2.
        @(negedge clk);
        in_valid0 = 1'b1;
        a0 = 8'h12;
        b0 = 8'h34;
        @(posedge clk);
        #1 in_valid0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst step2 mul_a", 32'(mul_a0), 32'd1);
        check_eq("rst step2 mul_b", 32'(mul_b0), 32'd4);
        #1 rst_n = 1'b0;
        #1;
        check_eq("async rst out_valid", 32'(out_valid0), 32'd0);
        check_eq("async rst p", 32'(p0), 32'd0);
        check_eq("async rst in_ready", 32'(in_ready0), 32'd1);
        check_eq("async rst mul_a", 32'(mul_a0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_eq("post rst no output", 32'(out_valid0), 32'd0);
        run0(8'h03, 8'h05, 16'h000F, "post-reset 03x05");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
